nibble_serial_adder: RTL and testbench

//  Multi-nibble adder for two NIBBLES*4-bit operands plus carry-in. Computes one 4-bit slice per clock, feeding the carry back

---
 rtl/nsa_pkg.sv | 23 ++
 rtl/nibble_add_slice.sv | 12 +
 rtl/nibble_serial_adder.sv | 122 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } nsa_state_e;

  // Largest legal decimal digit; a slice result above this needs the +6 correction.
  localparam logic [4:0] BCD_LIMIT = 5'd9;
  localparam logic [3:0] BCD_ADJ   = 4'd6;

  // Width of the nibble index; a single-nibble adder still needs a 1-bit index.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit adder slice: a + b + cin -> {cout, sum}.
module nibble_add_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder that reuses one 4-bit slice, one nibble per clock,
// with valid/ready handshakes on operands and result.
// Optional feature: define BCD_MODE_EN to treat each nibble as a decimal
// digit (decimal-adjust after each slice add, no extra latency).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | adding nibble idx per cycle, carry fed back between slices
// DONE  | result presented on sum/cout with out_valid until out_ready
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  nsa_state_e    state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          cout_q;

  logic [3:0]    a_nib, b_nib, slice_s, adj_s;
  logic          slice_c, adj_c;
  logic          accept;

  assign accept = (state_q == IDLE) && in_valid;

  // Operand nibble for the current slice; {idx,2'b00} keeps the bit offset wide enough.
  assign a_nib = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib = b_q[{idx_q, 2'b00} +: 4];

  nibble_add_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_s),
    .cout (slice_c)
  );

`ifdef BCD_MODE_EN
  // Decimal adjust: any slice total above 9 wraps by +6 and always carries.
  always_comb begin
    adj_s = slice_s;
    adj_c = 1'b0;
    if ({slice_c, slice_s} > BCD_LIMIT) begin
      adj_s = slice_s + BCD_ADJ;
      adj_c = 1'b1;
    end
  end
`else
  assign adj_s = slice_s;
  assign adj_c = slice_c;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)            state_d = RUN;
      RUN:     if (idx_q == IDX_LAST)   state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then write one result nibble per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[{idx_q, 2'b00} +: 4] <= adj_s;
      carry_q <= adj_c;
      if (idx_q == IDX_LAST) begin
        cout_q <= adj_c;
        idx_q  <= '0;
      end else begin
        idx_q  <= idx_q + IW'(1);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random
// operands with random stalls, checked against a whole-word reference model.
module tb_nibble_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
  localparam int LAT_BUDGET = 3 * NIB + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int chk_count = 0;
  int err_count = 0;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: whole-operand addition (binary) or digit-wise decimal-adjust rule.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
`ifdef BCD_MODE_EN
    logic [W-1:0] r;
    int           carry;
    int           t;
    r = '0;
    carry = int'(c);
    for (int i = 0; i < NIB; i++) begin
      t = int'((x >> (4 * i)) & 'hF) + int'((y >> (4 * i)) & 'hF) + carry;
      if (t > 9) begin
        r = r | (W'((t + 6) % 16) << (4 * i));
        carry = 1;
      end else begin
        r = r | (W'(t) << (4 * i));
        carry = 0;
      end
    end
    return {carry[0], r};
`else
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
`endif
  endfunction

  function automatic logic [W-1:0] rand_w();
    return W'({$urandom, $urandom});
  endfunction

  // One full transaction: accept, count latency, hold for `stall` cycles, then drain.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input int stall, input logic [W-1:0] es, input logic ec);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    cin       = tc;
    out_ready = 1'b0;
    check_eq("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    check_eq("busy_after_accept", busy, 1);
    check_eq("in_ready_after_accept", in_ready, 0);
    a        = rand_w();
    b        = rand_w();
    cin      = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
    n = 0;
    while (n < LAT_BUDGET) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
      in_valid = 1'($urandom_range(0, 1));
      a        = rand_w();
    end
    check_eq("latency", n, NIB);
    for (int s = 0; s < stall; s++) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_sum", sum, es);
      check_eq("hold_cout", cout, ec);
      check_eq("hold_in_ready", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      b        = rand_w();
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("out_valid", out_valid, 1);
    check_eq("sum", sum, es);
    check_eq("cout", cout, ec);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("drain_valid", out_valid, 0);
    check_eq("drain_in_ready", in_ready, 1);
    check_eq("drain_busy", busy, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   exp;

    // Reset state
    #2;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

`ifdef BCD_MODE_EN
    do_op(16'h0999, 16'h0001, 1'b0, 0, 16'h1000, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 0, 16'h0000, 1'b1);
    do_op(16'h1234, 16'h4321, 1'b1, 5, 16'h5556, 1'b0);
    do_op(16'h5678, 16'h4321, 1'b1, 1, 16'h0000, 1'b1);
`else
    do_op(16'h0000, 16'h0001, 1'b0, 0, 16'h0001, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1);
    do_op(16'h1234, 16'h4321, 1'b1, 5, 16'h5556, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 2, 16'hFFFF, 1'b1);
`endif

    // Abort mid-RUN (idx=2) with an asynchronous reset
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h8888;
    b = 16'h8888;
    cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_sum", sum, 0);
    check_eq("abort_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("abort_no_output", out_valid, 0);
    end
    exp = ref_add(16'h00FF, 16'h0001, 1'b0);
`ifdef BCD_MODE_EN
    do_op(16'h00FF, 16'h0001, 1'b0, 0, exp[W-1:0], exp[W]);
`else
    do_op(16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 1'b0);
`endif

    // Random operands, random stalls
    for (int i = 0; i < 150; i++) begin
      ra = rand_w();
      rb = rand_w();
      rc = 1'($urandom_range(0, 1));
      if (i % 5 == 0) ra = '1;
      exp = ref_add(ra, rb, rc);
      do_op(ra, rb, rc, int'($urandom_range(0, 3)), exp[W-1:0], exp[W]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", chk_count, err_count);
    $finish;
  end

endmodule
